booth_mult: RTL and testbench
=============================

BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 Parameter: ITERS, 16, radix-4 iteration count, fixed at WIDTH/2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: clr_n  input  1  asynchronous active-low reset.
REQ-005 Port: ctrl_MULT  input  1  start pulse; operands are sampled on the edge where it is high.
REQ-006 Port: data_operandA  input  32  multiplicand, two's complement.
REQ-007 Port: data_operandB  input  32  multiplier, two's complement.
REQ-008 Port: data_result  output  32  low 32 bits of the signed product.
REQ-009 Port: data_exception  output  1  signed overflow flag, valid while data_resultRDY is high.
REQ-010 Port: data_resultRDY  output  1  one-cycle result-valid pulse.

Function
REQ-011 FSM SHALL have states IDLE, RUN and DONE.
REQ-012 IDLE and ctrl_MULT high SHALL latch both operands, clear the iteration counter and clear the product register; the FSM SHALL move to RUN.
- Product register: 65 bits = {upper 33, multiplier 32} plus a 1-bit Booth guard initialised to 0.
REQ-013 RUN, each cycle SHALL perform one radix-4 step:
- Decode {P[1:0], guard} to 0, +A, +2A, -2A, -A.
- Add the selected value into the 34-bit sign-extended upper partial.
- Arithmetic-shift the full register right by 2.
- Increment the counter.
REQ-014 After the 16th RUN step (counter reaches 15 with step applied), the FSM SHALL enter DONE.
REQ-015 DONE SHALL assert data_resultRDY for exactly one cycle, then return to IDLE.
REQ-016 Latency SHALL be fixed: ctrl_MULT sampled at edge 0 gives data_resultRDY high after edge 17, 17 cycles total.
REQ-017 data_result SHALL hold product bits [31:0] from DONE until the next ctrl_MULT is accepted.
REQ-018 data_exception SHALL be 1 iff product bits [63:32] are not all equal to product bit 31.
REQ-019 ctrl_MULT high in RUN or DONE SHALL abort the current operation, relatch operands and restart at iteration 0; no data_resultRDY SHALL be issued for the aborted operation.
REQ-020 ctrl_MULT held high for several cycles SHALL restart on every sampled cycle; the result follows the last sample.
REQ-021 Operand inputs SHALL be ignored except on ctrl_MULT edges.
REQ-022 -2A and -A SHALL be formed as inverted A or 2A plus carry-in 1; no separate negation adder.
REQ-023 The most negative multiplicand, 0x80000000, SHALL produce correct results via the 34-bit partial width.

Reset
REQ-024 clr_n low SHALL immediately force IDLE, counter 0, product register 0, data_result 0, data_exception 0 and data_resultRDY 0, independent of clk.
REQ-025 Reset asserted mid-RUN SHALL discard the operation; no data_resultRDY SHALL follow deassertion.
REQ-026 The first ctrl_MULT SHALL be accepted on the first rising edge after clr_n deasserts.

Structure
REQ-027 Shared package SHALL hold: the FSM state encoding, the Booth operation encoding (ZERO, PA, P2A, M2A, MA), the WIDTH and ITERS constants, and LAST_ITER = 15.
REQ-028 Iteration count SHALL use one sub-module instance, counter64, driven by:
- clk
- T = (state == RUN)
- synchronous clear on operand latch
- upper bits ignored above LAST_ITER.
REQ-029 Booth decode and adder SHALL be combinational in the same module; there SHALL be no second sequential sub-module.

Verification
REQ-030 A=3, B=5, ctrl_MULT pulse -> data_resultRDY exactly 17 cycles later, result 0x0000000F, exception 0.
REQ-031 A=-7, B=6 -> result 0xFFFFFFD6, exception 0; A=0x80000000, B=1 -> result 0x80000000, exception 0.
REQ-032 A=0x7FFFFFFF, B=2 -> result 0xFFFFFFFE, exception 1; A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-033 Start A=3, B=5; at cycle 8 pulse ctrl_MULT with A=10, B=10 -> single data_resultRDY 17 cycles after the second pulse, result 100.
REQ-034 Start an operation; drop clr_n at cycle 5 for 2 cycles -> all outputs 0, and no data_resultRDY for 40 cycles.
REQ-035 Random signed pairs, 1000 runs -> result equals the 64-bit reference product [31:0], exception matches REQ-018, and resultRDY is exactly one cycle wide each run.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// Shared constants, FSM state and Booth operation encodings for the radix-4 multiplier.
package booth_mult_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned ITERS     = WIDTH / 2;
    localparam int unsigned LAST_ITER = ITERS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PA   = 3'd1,
        P2A  = 3'd2,
        M2A  = 3'd3,
        MA   = 3'd4
    } booth_op_e;

    // Radix-4 recoding of {b[i+1], b[i], b[i-1]}
    function automatic booth_op_e booth_decode(input logic [2:0] bits);
        booth_op_e op;
        case (bits)
            3'b001, 3'b010: op = PA;
            3'b011:         op = P2A;
            3'b100:         op = M2A;
            3'b101, 3'b110: op = MA;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_counter64.sv
// Free-running 64-bit iteration counter with toggle-enable and synchronous clear.
module booth_mult_counter64 (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        i_t,
    input  logic        i_clr,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_t) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-4 Booth multiplier: 16 steps per product, low word plus overflow flag out.
module booth_mult #(
    parameter int unsigned WIDTH = booth_mult_pkg::WIDTH,
    parameter int unsigned ITERS = booth_mult_pkg::ITERS
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    import booth_mult_pkg::*;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH:0]   r_upper;
    logic [WIDTH-1:0] r_low;
    logic             r_guard;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;

    booth_op_e        w_op;
    logic [WIDTH+1:0] w_a1;
    logic [WIDTH+1:0] w_a2;
    logic [WIDTH+1:0] w_addend;
    logic             w_neg;
    logic [WIDTH+1:0] w_sum;
    logic [63:0]      w_count;
    logic             w_run;
    logic             w_last;

    assign w_run  = (r_state == RUN);
    assign w_last = (w_count == 64'(ITERS - 1));

    booth_mult_counter64 counter64 (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_t     (w_run),
        .i_clr   (ctrl_MULT),
        .o_count (w_count)
    );

    // 34-bit partial keeps +/-2A exact even for the most negative multiplicand
    assign w_a1 = {{2{r_a[WIDTH-1]}}, r_a};
    assign w_a2 = {r_a[WIDTH-1], r_a, 1'b0};
    assign w_op = booth_decode({r_low[1:0], r_guard});

    always_comb begin
        w_addend = '0;
        w_neg    = 1'b0;
        case (w_op)
            PA:      w_addend = w_a1;
            P2A:     w_addend = w_a2;
            M2A: begin
                w_addend = ~w_a2;
                w_neg    = 1'b1;
            end
            MA: begin
                w_addend = ~w_a1;
                w_neg    = 1'b1;
            end
            default: w_addend = '0;
        endcase
    end

    // Subtraction reuses the single adder via inverted operand plus carry-in
    assign w_sum = {r_upper[WIDTH], r_upper} + w_addend + {{(WIDTH+1){1'b0}}, w_neg};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_upper  <= '0;
            r_low    <= '0;
            r_guard  <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (ctrl_MULT) begin
                r_a     <= data_operandA;
                r_upper <= '0;
                r_low   <= data_operandB;
                r_guard <= 1'b0;
                r_state <= RUN;
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    RUN: begin
                        r_upper <= {w_sum[WIDTH+1], w_sum[WIDTH+1:2]};
                        r_low   <= {w_sum[1:0], r_low[WIDTH-1:2]};
                        r_guard <= r_low[1];
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                    DONE: begin
                        r_rdy    <= 1'b1;
                        r_result <= r_low;
                        r_exc    <= (r_upper[WIDTH-1:0] != {WIDTH{r_low[WIDTH-1]}});
                        r_state  <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed vectors, abort/reset sequences, random pairs.
module tb_booth_mult;

    logic        clk;
    logic        clr_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[10];

    booth_mult #(
        .WIDTH (32),
        .ITERS (16)
    ) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: full 64-bit signed product, overflow when it does not fit in 32 signed bits
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        logic   ovf;
        logic [63:0] pv;
        sa  = $signed(a);
        sb  = $signed(b);
        p   = sa * sb;
        ovf = (p > 64'sh0000_0000_7FFF_FFFF) || (p < -64'sh0000_0000_8000_0000);
        pv  = p;
        return {ovf, pv[31:0]};
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clk);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Called just after the accepting edge; lat counts edges until resultRDY is seen
    task automatic wait_done(output int lat, output logic [31:0] res, output logic exc,
                             output logic rdy_after);
        lat       = 0;
        res       = '0;
        exc       = 1'b0;
        rdy_after = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (data_resultRDY) begin
                lat = c;
                res = data_result;
                exc = data_exception;
                break;
            end
            data_operandA = $urandom;
            data_operandB = $urandom;
        end
        if (lat != 0) begin
            @(negedge clk);
            rdy_after = data_resultRDY;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        exc;
        logic        rdy_after;
        logic [32:0] ref_v;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rdy_seen;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{a: 32'h0000_0003, b: 32'h0000_0005, res: 32'h0000_000F, exc: 1'b0};
        vecs[1] = '{a: 32'hFFFF_FFF9, b: 32'h0000_0006, res: 32'hFFFF_FFD6, exc: 1'b0};
        vecs[2] = '{a: 32'h8000_0000, b: 32'h0000_0001, res: 32'h8000_0000, exc: 1'b0};
        vecs[3] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, res: 32'h8000_0000, exc: 1'b1};
        vecs[4] = '{a: 32'h0000_0000, b: 32'h1234_5678, res: 32'h0000_0000, exc: 1'b0};
        vecs[5] = '{a: 32'h8000_0000, b: 32'h8000_0000, res: 32'h0000_0000, exc: 1'b1};
        vecs[6] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'h0000_0001, exc: 1'b0};
        vecs[7] = '{a: 32'h0001_0000, b: 32'h0001_0000, res: 32'h0000_0000, exc: 1'b1};
        vecs[8] = '{a: 32'h0001_2345, b: 32'h0000_1000, res: 32'h1234_5000, exc: 1'b0};
        vecs[9] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0002, res: 32'hFFFF_FFFE, exc: 1'b1};

        clr_n         = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("reset_result", 64'(data_result), 64'h0);
        check("reset_exception", 64'(data_exception), 64'h0);
        check("reset_rdy", 64'(data_resultRDY), 64'h0);

        // Start on the very first edge after reset release
        @(negedge clk);
        clr_n         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd5;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        wait_done(lat, res, exc, rdy_after);
        check("first_after_reset_latency", 64'(lat), 64'd17);
        check("first_after_reset_result", 64'(res), 64'h0000_000F);
        check("first_after_reset_exception", 64'(exc), 64'h0);
        check("first_after_reset_rdy_width", 64'(rdy_after), 64'h0);

        for (int i = 0; i < 10; i++) begin
            start(vecs[i].a, vecs[i].b);
            wait_done(lat, res, exc, rdy_after);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
            check($sformatf("vec%0d_exception", i), 64'(exc), 64'(vecs[i].exc));
            check($sformatf("vec%0d_rdy_width", i), 64'(rdy_after), 64'h0);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_result_hold", i), 64'(data_result), 64'(vecs[i].res));
        end

        // Reset mid-run discards the operation and clears outputs immediately
        start(32'd123, 32'd456);
        repeat (4) @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("midrun_reset_result", 64'(data_result), 64'h0);
        check("midrun_reset_exception", 64'(data_exception), 64'h0);
        check("midrun_reset_rdy", 64'(data_resultRDY), 64'h0);
        repeat (2) @(negedge clk);
        clr_n    = 1'b1;
        rdy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (data_resultRDY) rdy_seen++;
        end
        check("midrun_reset_no_rdy", 64'(rdy_seen), 64'h0);
        check("midrun_reset_result_after", 64'(data_result), 64'h0);

        // Abort in RUN: only the second operation completes
        start(32'd3, 32'd5);
        repeat (7) @(negedge clk);
        start(32'd10, 32'd10);
        wait_done(lat, res, exc, rdy_after);
        check("abort_latency", 64'(lat), 64'd17);
        check("abort_result", 64'(res), 64'd100);
        check("abort_rdy_width", 64'(rdy_after), 64'h0);

        // Held start restarts each cycle; last sample wins
        @(negedge clk);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd11;
        data_operandB = 32'd13;
        @(negedge clk);
        data_operandA = 32'hFFFF_FFFB;
        data_operandB = 32'd4;
        @(negedge clk);
        data_operandA = 32'd7;
        data_operandB = 32'd9;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        wait_done(lat, res, exc, rdy_after);
        check("held_latency", 64'(lat), 64'd17);
        check("held_result", 64'(res), 64'd63);
        check("held_exception", 64'(exc), 64'h0);

        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    ra = $urandom;
                    rb = $urandom;
                end
                1: begin
                    ra = 32'($urandom_range(0, 200)) - 32'd100;
                    rb = 32'($urandom_range(0, 200)) - 32'd100;
                end
                2: begin
                    ra = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    rb = $urandom;
                end
                default: begin
                    ra = $urandom;
                    rb = 32'($urandom_range(0, 70000)) - 32'd35000;
                end
            endcase
            ref_v = model(ra, rb);
            start(ra, rb);
            wait_done(lat, res, exc, rdy_after);
            check($sformatf("rand%0d_latency a=%0h b=%0h", n, ra, rb), 64'(lat), 64'd17);
            check($sformatf("rand%0d_result a=%0h b=%0h", n, ra, rb), 64'(res),
                  64'(ref_v[31:0]));
            check($sformatf("rand%0d_exception a=%0h b=%0h", n, ra, rb), 64'(exc),
                  64'(ref_v[32]));
            check($sformatf("rand%0d_rdy_width", n), 64'(rdy_after), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
